// File: rtl/legv8_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/flags in, control word and immediate out.
// master = control unit, slave = datapath.
interface legv8_control_unit_if;
    logic [31:0] IR_out;
    logic [4:0]  status;
    logic [3:0]  current_status;
    logic [39:0] ControlWord;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;

    modport master (
        input  IR_out, status, current_status,
        output ControlWord, constant, state, halted
    );

    modport slave (
        output IR_out, status, current_status,
        input  ControlWord, constant, state, halted
    );
endinterface

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit: FETCH/EXEC/LOAD2/CBR sequencing into a 40-bit ControlWord.
// Define LEGV8_CU_ILLEGAL_HALT_EN to halt on illegal opcodes instead of treating them as NOP.
module legv8_control_unit #(
    parameter logic [1:0] FETCH_DS = 2'b11,
    parameter logic [1:0] SIZE_DW  = 2'b11
) (
    input logic                  clock,
    input logic                  reset,
    legv8_control_unit_if.master cu
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        LOAD2 = 3'd2,
        CBR   = 3'd3,
        HALT  = 3'd4
    } state_e;

    typedef struct packed {
        logic [6:0] rsvd;
        logic [1:0] ds;
        logic [1:0] ps;
        logic       as_pc;
        logic       bs_k;
        logic       il;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mw;
        logic       rw;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } cw_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    state_e      state_q, state_d;
    logic        flag_q, flag_d;
    logic [31:0] ir;
    logic [63:0] imm12_k, d9_k, br26_k, br19_k;
    cw_t         r_word, i_word, m_word, cw;
    logic [63:0] k;
    logic [1:0]  ps_sel;

    // ARM condition codes on {N,Z,C,V}; odd codes invert the even base, except 1111 (always).
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond[0] && cond[3:1] != 3'b111) ? ~base : base;
    endfunction

    // NOTE: synchronous reset lives inside the clocked block; state uses <= only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    assign ir      = cu.IR_out;
    assign imm12_k = {52'b0, ir[21:10]};
    assign d9_k    = {{55{ir[20]}}, ir[20:12]};
    assign br26_k  = {{36{ir[25]}}, ir[25:0], 2'b00};
    assign br19_k  = {{43{ir[23]}}, ir[23:5], 2'b00};

    always_comb begin
        r_word    = '0;
        r_word.da = ir[4:0];
        r_word.sa = ir[9:5];
        r_word.sb = ir[20:16];
        r_word.rw = 1'b1;

        i_word      = '0;
        i_word.da   = ir[4:0];
        i_word.sa   = ir[9:5];
        i_word.rw   = 1'b1;
        i_word.bs_k = 1'b1;

        m_word      = '0;
        m_word.sa   = ir[9:5];
        m_word.bs_k = 1'b1;
        m_word.fs   = FS_ADD;
        m_word.size = SIZE_DW;
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        cw      = '0;
        k       = '0;
        ps_sel  = 2'b01;
        state_d = state_q;
        flag_d  = flag_q;

        case (state_q)
            FETCH: begin
                cw.as_pc = 1'b1;
                cw.ds    = FETCH_DS;
                cw.il    = 1'b1;
                cw.size  = SIZE_DW;
                state_d  = EXEC;
            end

            EXEC: begin
                state_d = FETCH;
                casez (ir[31:21])
                    11'b10001011000: begin cw = r_word; cw.fs = FS_ADD; end
                    11'b11001011000: begin cw = r_word; cw.fs = FS_SUB; cw.c0 = 1'b1; end
                    11'b10001010000: begin cw = r_word; cw.fs = FS_AND; end
                    11'b10101010000: begin cw = r_word; cw.fs = FS_ORR; end
                    11'b11101011000: begin
                        cw    = r_word;
                        cw.fs = FS_SUB;
                        cw.c0 = 1'b1;
                        cw.sl = 1'b1;
                    end
                    11'b1001000100?: begin cw = i_word; cw.fs = FS_ADD; k = imm12_k; end
                    11'b1101000100?: begin cw = i_word; cw.fs = FS_SUB; cw.c0 = 1'b1; k = imm12_k; end
                    11'b1001001000?: begin cw = i_word; cw.fs = FS_AND; k = imm12_k; end
                    11'b1011001000?: begin cw = i_word; cw.fs = FS_ORR; k = imm12_k; end
                    11'b11111000000: begin
                        cw    = m_word;
                        cw.sb = ir[4:0];
                        cw.mw = 1'b1;
                        cw.ds = 2'b01;
                        k     = d9_k;
                    end
                    11'b11111000010: begin
                        cw      = m_word;
                        cw.da   = ir[4:0];
                        cw.ds   = 2'b11;
                        k       = d9_k;
                        ps_sel  = 2'b00;
                        state_d = LOAD2;
                    end
                    11'b000101?????: begin
                        ps_sel = 2'b11;
                        k      = br26_k;
                    end
                    11'b01010100???: begin
                        ps_sel = cond_true(ir[3:0], cu.current_status) ? 2'b11 : 2'b01;
                        k      = br19_k;
                    end
                    11'b1011010????: begin
                        cw.sa   = 5'd31;
                        cw.sb   = ir[4:0];
                        cw.fs   = FS_ORR;
                        ps_sel  = 2'b00;
                        flag_d  = cu.status[0] ^ ir[24];
                        state_d = CBR;
                    end
                    default: begin
`ifdef LEGV8_CU_ILLEGAL_HALT_EN
                        ps_sel  = 2'b00;
                        state_d = HALT;
`else
                        ps_sel  = 2'b01;
`endif
                    end
                endcase
                cw.ps = ps_sel;
            end

            // Second LDUR cycle: same address/data path, now writing the register and advancing PC.
            LOAD2: begin
                cw      = m_word;
                cw.da   = ir[4:0];
                cw.ds   = 2'b11;
                cw.rw   = 1'b1;
                cw.ps   = 2'b01;
                k       = d9_k;
                state_d = FETCH;
            end

            CBR: begin
                cw.ps   = flag_q ? 2'b11 : 2'b01;
                k       = br19_k;
                state_d = FETCH;
            end

            HALT: begin
`ifdef LEGV8_CU_ILLEGAL_HALT_EN
                state_d = HALT;
`else
                state_d = FETCH;
`endif
            end

            default: state_d = FETCH;
        endcase
    end

    assign cu.ControlWord = reset ? 40'd0 : cw;
    assign cu.constant    = reset ? 64'd0 : k;
    assign cu.state       = state_q;
`ifdef LEGV8_CU_ILLEGAL_HALT_EN
    assign cu.halted      = (state_q == HALT);
`else
    assign cu.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit: expected words are queued when inputs are driven
// and popped for comparison half a cycle later.
module tb_legv8_control_unit;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    legv8_control_unit_if bus ();

    legv8_control_unit dut (
        .clock (clock),
        .reset (reset),
        .cu    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [39:0] cw;
        logic [63:0] k;
        logic [2:0]  st;
        logic        h;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    function automatic logic [39:0] mk(
        input logic [4:0] sb, input logic [4:0] sa, input logic [4:0] da,
        input logic rw, input logic mw, input logic [1:0] size, input logic c0,
        input logic [4:0] fs, input logic sl, input logic il, input logic bs,
        input logic as_pc, input logic [1:0] ps, input logic [1:0] ds);
        logic [39:0] w;
        w        = '0;
        w[4:0]   = sb;
        w[9:5]   = sa;
        w[14:10] = da;
        w[15]    = rw;
        w[16]    = mw;
        w[18:17] = size;
        w[19]    = c0;
        w[24:20] = fs;
        w[25]    = sl;
        w[26]    = il;
        w[27]    = bs;
        w[28]    = as_pc;
        w[30:29] = ps;
        w[32:31] = ds;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, queue expectation, compare on the falling edge, advance.
    task automatic step(input string tag, input logic rst, input logic [31:0] ir,
                        input logic [4:0] st, input logic [3:0] cs,
                        input logic [39:0] ecw, input logic [63:0] ek,
                        input logic [2:0] es, input logic eh);
        exp_t  e;
        string t;
        reset                 = rst;
        bus.IR_out            = ir;
        bus.status            = st;
        bus.current_status    = cs;
        sb_q.push_back(exp_t'{cw: ecw, k: ek, st: es, h: eh});
        tag_q.push_back(tag);
        @(negedge clock);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".cw"},     64'(bus.ControlWord), 64'(e.cw));
        check({t, ".const"},  bus.constant,         e.k);
        check({t, ".state"},  64'(bus.state),       64'(e.st));
        check({t, ".halted"}, 64'(bus.halted),      64'(e.h));
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] I_ADDI  = 32'h910063E0;  // ADDI X0,XZR,#24
    localparam logic [31:0] I_LDUR  = 32'hF84003E2;  // LDUR X2,[XZR,#0]
    localparam logic [31:0] I_STUR  = 32'hF81F8023;  // STUR X3,[X1,#-8]
    localparam logic [31:0] I_SUBS  = 32'hEB0700C5;  // SUBS X5,X6,X7
    localparam logic [31:0] I_ORR   = 32'hAA030041;  // ORR X1,X2,X3
    localparam logic [31:0] I_CBZ   = 32'hB4000101;  // CBZ X1,#+8 words
    localparam logic [31:0] I_CBNZ  = 32'hB5000101;  // CBNZ X1,#+8 words
    localparam logic [31:0] I_BEQ   = 32'h54FFFFE0;  // B.EQ -1 word
    localparam logic [31:0] I_BLT   = 32'h5400008B;  // B.LT +4 words
    localparam logic [31:0] I_BHI   = 32'h54000088;  // B.HI +4 words
    localparam logic [31:0] I_B     = 32'h14000003;  // B +3 words
    localparam logic [31:0] I_ILL   = 32'h00000000;

    logic [39:0] w_fetch, w_addi, w_ld1, w_ld2, w_stur, w_subs, w_orr, w_cbz;
    logic [39:0] w_pc4, w_pcbr, w_zero;

    initial begin
        n_vec = 0;
        n_err = 0;
        w_fetch = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11);
        w_addi  = mk(5'd0, 5'd31, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
        w_ld1   = mk(5'd0, 5'd31, 5'd2, 1'b0, 1'b0, 2'b11, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11);
        w_ld2   = mk(5'd0, 5'd31, 5'd2, 1'b1, 1'b0, 2'b11, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b11);
        w_stur  = mk(5'd3, 5'd1, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01);
        w_subs  = mk(5'd7, 5'd6, 5'd5, 1'b1, 1'b0, 2'b00, 1'b1, 5'b01001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        w_orr   = mk(5'd3, 5'd2, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        w_cbz   = mk(5'd1, 5'd31, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        w_pc4   = 40'd1 << 29;
        w_pcbr  = 40'd3 << 29;
        w_zero  = 40'd0;

        reset              = 1'b1;
        bus.IR_out         = I_ADDI;
        bus.status         = 5'd0;
        bus.current_status = 4'd0;
        @(posedge clock);
        #1;

        // Reset held two cycles, outputs forced to zero even with a live instruction present.
        step("rst0", 1'b1, I_ADDI, 5'd0, 4'd0, w_zero, 64'd0, 3'd0, 1'b0);
        step("rst1", 1'b1, I_ADDI, 5'd0, 4'd0, w_zero, 64'd0, 3'd0, 1'b0);

        step("addi.f", 1'b0, I_ADDI, 5'd0, 4'd0, w_fetch, 64'd0,  3'd0, 1'b0);
        step("addi.x", 1'b0, I_ADDI, 5'd0, 4'd0, w_addi,  64'd24, 3'd1, 1'b0);

        step("ldur.f", 1'b0, I_LDUR, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
        step("ldur.x", 1'b0, I_LDUR, 5'd0, 4'd0, w_ld1,   64'd0, 3'd1, 1'b0);
        step("ldur.2", 1'b0, I_LDUR, 5'd0, 4'd0, w_ld2,   64'd0, 3'd2, 1'b0);

        step("stur.f", 1'b0, I_STUR, 5'd0, 4'd0, w_fetch, 64'd0,                  3'd0, 1'b0);
        step("stur.x", 1'b0, I_STUR, 5'd0, 4'd0, w_stur,  64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0);

        step("subs.f", 1'b0, I_SUBS, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
        step("subs.x", 1'b0, I_SUBS, 5'd0, 4'd0, w_subs,  64'd0, 3'd1, 1'b0);

        step("orr.f", 1'b0, I_ORR, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
        step("orr.x", 1'b0, I_ORR, 5'd0, 4'd0, w_orr,   64'd0, 3'd1, 1'b0);

        // CBZ taken: status flips in CBR to show the decision came from the latched flag.
        step("cbz1.f", 1'b0, I_CBZ, 5'd1, 4'd0, w_fetch, 64'd0,  3'd0, 1'b0);
        step("cbz1.x", 1'b0, I_CBZ, 5'd1, 4'd0, w_cbz,   64'd0,  3'd1, 1'b0);
        step("cbz1.c", 1'b0, I_CBZ, 5'd0, 4'd0, w_pcbr,  64'd32, 3'd3, 1'b0);
        step("cbz0.f", 1'b0, I_CBZ, 5'd0, 4'd0, w_fetch, 64'd0,  3'd0, 1'b0);
        step("cbz0.x", 1'b0, I_CBZ, 5'd0, 4'd0, w_cbz,   64'd0,  3'd1, 1'b0);
        step("cbz0.c", 1'b0, I_CBZ, 5'd1, 4'd0, w_pc4,   64'd32, 3'd3, 1'b0);
        step("cbnz.f", 1'b0, I_CBNZ, 5'd0, 4'd0, w_fetch, 64'd0,  3'd0, 1'b0);
        step("cbnz.x", 1'b0, I_CBNZ, 5'd0, 4'd0, w_cbz,   64'd0,  3'd1, 1'b0);
        step("cbnz.c", 1'b0, I_CBNZ, 5'd1, 4'd0, w_pcbr,  64'd32, 3'd3, 1'b0);

        step("beq1.f", 1'b0, I_BEQ, 5'd0, 4'b0100, w_fetch, 64'd0,                  3'd0, 1'b0);
        step("beq1.x", 1'b0, I_BEQ, 5'd0, 4'b0100, w_pcbr,  64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
        step("beq0.f", 1'b0, I_BEQ, 5'd0, 4'b0000, w_fetch, 64'd0,                  3'd0, 1'b0);
        step("beq0.x", 1'b0, I_BEQ, 5'd0, 4'b0000, w_pc4,   64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
        step("blt.f",  1'b0, I_BLT, 5'd0, 4'b1000, w_fetch, 64'd0,  3'd0, 1'b0);
        step("blt.x",  1'b0, I_BLT, 5'd0, 4'b1000, w_pcbr,  64'd16, 3'd1, 1'b0);
        step("bhi.f",  1'b0, I_BHI, 5'd0, 4'b0110, w_fetch, 64'd0,  3'd0, 1'b0);
        step("bhi.x",  1'b0, I_BHI, 5'd0, 4'b0110, w_pc4,   64'd16, 3'd1, 1'b0);

        step("b.f", 1'b0, I_B, 5'd0, 4'd0, w_fetch, 64'd0,  3'd0, 1'b0);
        step("b.x", 1'b0, I_B, 5'd0, 4'd0, w_pcbr,  64'd12, 3'd1, 1'b0);

        // Reset during LOAD2 abandons the load; the next cycle is a fresh FETCH.
        step("ldrst.f", 1'b0, I_LDUR, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
        step("ldrst.x", 1'b0, I_LDUR, 5'd0, 4'd0, w_ld1,   64'd0, 3'd1, 1'b0);
        step("ldrst.2", 1'b1, I_LDUR, 5'd0, 4'd0, w_zero,  64'd0, 3'd2, 1'b0);
        step("ldrst.n", 1'b0, I_LDUR, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
        step("ldrst.a", 1'b0, I_LDUR, 5'd0, 4'd0, w_ld1,   64'd0, 3'd1, 1'b0);
        step("ldrst.b", 1'b0, I_LDUR, 5'd0, 4'd0, w_ld2,   64'd0, 3'd2, 1'b0);

        step("ill.f", 1'b0, I_ILL, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
`ifdef LEGV8_CU_ILLEGAL_HALT_EN
        step("ill.x", 1'b0, I_ILL, 5'd0, 4'd0, w_zero, 64'd0, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("halt%0d", i), 1'b0, I_ADDI, 5'd0, 4'd0, w_zero, 64'd0, 3'd4, 1'b1);
        end
        step("halt.rst", 1'b1, I_ADDI, 5'd0, 4'd0, w_zero,  64'd0, 3'd4, 1'b1);
        step("halt.out", 1'b0, I_ADDI, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
`else
        step("ill.x",  1'b0, I_ILL,  5'd0, 4'd0, w_pc4,   64'd0, 3'd1, 1'b0);
        step("ill.nf", 1'b0, I_ADDI, 5'd0, 4'd0, w_fetch, 64'd0, 3'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
